// File: rtl/popcount_stream_acc.sv
// Streaming per-word bit counter with a saturating per-frame running total,
// threshold flag and a single registered output stage with backpressure.
module popcount_stream_acc #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 12,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             count_zeros,
  input  logic             clear,
  input  logic [ACC_W-1:0] thresh,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic [ACC_W-1:0] out_total,
  output logic             out_hit,
  output logic             out_sat,
  output logic             out_last
);

  localparam int SUM_W = ACC_W + 1;
  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic [ACC_W-1:0] out_total_q, out_total_d;
  logic             out_hit_q,   out_hit_d;
  logic             out_sat_q,   out_sat_d;
  logic             out_last_q,  out_last_d;
  logic [ACC_W-1:0] acc_q,       acc_d;
  logic             sat_q,       sat_d;
  logic             start_q,     start_d;

  logic             accept;
  logic             base_from_acc;
  logic [CNT_W-1:0] ones_cnt;
  logic [CNT_W-1:0] word_cnt;
  logic [ACC_W-1:0] base;
  logic [SUM_W-1:0] sum_wide;
  logic             sat_evt;
  logic [ACC_W-1:0] total;
  logic             sat_flag;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    ones_cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ones_cnt = ones_cnt + CNT_W'(in_data[i]);
    end
  end

  assign word_cnt = count_zeros ? (CNT_W'(WIDTH) - ones_cnt) : ones_cnt;

  // A new frame (or a clear on this word) restarts the sum from zero.
  assign base_from_acc = !start_q && !clear;
  assign base          = base_from_acc ? acc_q : '0;
  assign sum_wide      = {1'b0, base} + SUM_W'(word_cnt);

  // base <= ACC_MAX and word_cnt <= WIDTH < 2^ACC_W, so the carry bit is
  // exactly the overflow condition.
  assign sat_evt  = sum_wide[ACC_W];
  assign total    = sat_evt ? ACC_MAX : sum_wide[ACC_W-1:0];
  assign sat_flag = sat_evt || (sat_q && base_from_acc);

  always_comb begin
    out_valid_d = out_valid_q;
    out_count_d = out_count_q;
    out_total_d = out_total_q;
    out_hit_d   = out_hit_q;
    out_sat_d   = out_sat_q;
    out_last_d  = out_last_q;
    acc_d       = acc_q;
    sat_d       = sat_q;
    start_d     = start_q;

    if (accept) begin
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      out_count_d = word_cnt;
      out_total_d = total;
      out_hit_d   = (total >= thresh);
      out_sat_d   = sat_flag;
      out_last_d  = in_last;
      acc_d       = total;
      sat_d       = sat_flag;
      start_d     = in_last;
    end else if (clear) begin
      // Abort only touches frame state; a held output stays as it is.
      acc_d   = '0;
      sat_d   = 1'b0;
      start_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_count_q <= '0;
      out_total_q <= '0;
      out_hit_q   <= 1'b0;
      out_sat_q   <= 1'b0;
      out_last_q  <= 1'b0;
      acc_q       <= '0;
      sat_q       <= 1'b0;
      start_q     <= 1'b1;
    end else begin
      out_valid_q <= out_valid_d;
      out_count_q <= out_count_d;
      out_total_q <= out_total_d;
      out_hit_q   <= out_hit_d;
      out_sat_q   <= out_sat_d;
      out_last_q  <= out_last_d;
      acc_q       <= acc_d;
      sat_q       <= sat_d;
      start_q     <= start_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_count = out_count_q;
  assign out_total = out_total_q;
  assign out_hit   = out_hit_q;
  assign out_sat   = out_sat_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_popcount_stream_acc.sv
// Scoreboard bench for popcount_stream_acc: a driver predicts each accepted
// word's result from an unbounded frame sum, a negedge monitor checks pops.
module tb_popcount_stream_acc;

  localparam int WIDTH = 8;
  localparam int ACC_W = 6;
  localparam int CNT_W = 4;
  localparam int MAXV  = (1 << ACC_W) - 1;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             count_zeros;
  logic             clear;
  logic [ACC_W-1:0] thresh;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] out_count;
  logic [ACC_W-1:0] out_total;
  logic             out_hit;
  logic             out_sat;
  logic             out_last;

  popcount_stream_acc #(.WIDTH(WIDTH), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .count_zeros(count_zeros), .clear(clear),
    .thresh(thresh),
    .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count),
    .out_total(out_total), .out_hit(out_hit), .out_sat(out_sat),
    .out_last(out_last)
  );

  typedef struct {
    int cnt;
    int total;
    bit hit;
    bit sat;
    bit last;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  int   frame_sum = 0;
  bit   new_frame = 1'b1;
  bit   m_valid = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
  endtask

  // Called at posedge+1; leaves the bench at the next posedge+1.
  task automatic cycle(input bit v, input logic [7:0] d, input bit l, input bit cz,
                       input bit clr, input bit ordy, input logic [ACC_W-1:0] th);
    bit   exp_ready;
    bit   acc;
    int   c;
    exp_t e;
    in_valid    = v;
    in_data     = d;
    in_last     = l;
    count_zeros = cz;
    clear       = clr;
    out_ready   = ordy;
    thresh      = th;
    exp_ready   = !m_valid || ordy;
    acc         = v && exp_ready;
    #1;
    check("in_ready", in_ready, exp_ready);
    check("out_valid", out_valid, m_valid);
    if (acc) begin
      if (new_frame || clr) frame_sum = 0;
      c = cz ? WIDTH - $countones(d) : $countones(d);
      frame_sum += c;
      e.cnt   = c;
      e.total = (frame_sum > MAXV) ? MAXV : frame_sum;
      e.sat   = frame_sum > MAXV;
      e.hit   = e.total >= int'(th);
      e.last  = l;
      exp_q.push_back(e);
      new_frame = l;
    end else if (clr) begin
      new_frame = 1'b1;
    end
    m_valid = acc ? 1'b1 : (ordy ? 1'b0 : m_valid);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_count", out_count, 0);
    check("rst_out_total", out_total, 0);
    check("rst_out_hit", out_hit, 0);
    check("rst_out_sat", out_sat, 0);
    check("rst_out_last", out_last, 0);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    clear    = 1'b0;
    rst      = 1'b1;
    #1;
    check_reset_state();
    exp_q.delete();
    m_valid   = 1'b0;
    new_frame = 1'b1;
    frame_sum = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_count", out_count, e.cnt);
        check("out_total", out_total, e.total);
        check("out_hit", out_hit, e.hit);
        check("out_sat", out_sat, e.sat);
        check("out_last", out_last, e.last);
        $display("pop: count=%0d total=%0d hit=%0d sat=%0d last=%0d", out_count,
                 out_total, out_hit, out_sat, out_last);
      end
    end
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; count_zeros = 1'b0;
    clear = 1'b0; thresh = '0; out_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_reset_state();
    check("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic counts and a frame boundary.
    cycle(1, 8'h00, 0, 0, 0, 1, 6'd63);
    cycle(1, 8'h01, 0, 0, 0, 1, 6'd63);
    cycle(1, 8'hFF, 0, 0, 0, 1, 6'd63);
    cycle(1, 8'hA5, 1, 0, 0, 1, 6'd63);
    cycle(1, 8'h0F, 0, 1, 0, 1, 6'd63);
    cycle(1, 8'hF0, 1, 0, 0, 1, 6'd63);
    // Saturation in a long frame, then recovery on the next frame.
    for (int i = 0; i < 8; i++) cycle(1, 8'hFF, 0, 0, 0, 1, 6'd10);
    cycle(1, 8'h03, 1, 0, 0, 1, 6'd10);
    cycle(1, 8'h01, 0, 0, 0, 1, 6'd10);
    // Threshold, then a stall with thresh changing while held.
    cycle(1, 8'hFF, 1, 0, 0, 1, 6'd10);
    cycle(1, 8'hFF, 0, 0, 0, 1, 6'd10);
    cycle(1, 8'h0F, 0, 0, 0, 0, 6'd10);
    cycle(1, 8'h01, 0, 0, 0, 0, 6'd20);
    cycle(1, 8'h01, 0, 0, 1, 0, 6'd20);
    cycle(1, 8'h03, 0, 0, 0, 1, 6'd20);
    cycle(1, 8'h07, 0, 0, 0, 1, 6'd20);
    // Clear with accept, then reset mid-frame.
    cycle(1, 8'h07, 0, 0, 1, 1, 6'd20);
    cycle(1, 8'h3F, 0, 0, 0, 0, 6'd20);
    do_reset();
    cycle(1, 8'h1F, 0, 0, 0, 1, 6'd20);
    cycle(1, 8'h01, 1, 0, 0, 1, 6'd20);

    // Randomized traffic with one asynchronous reset in the middle.
    for (int n = 0; n < 1500; n++) begin
      logic [7:0] d;
      int sel;
      sel = $urandom_range(0, 3);
      d = (sel == 0) ? 8'hFF : (sel == 1) ? 8'h00 : 8'($urandom);
      if (n == 700) do_reset();
      cycle($urandom_range(0, 9) < 8, d, $urandom_range(0, 9) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 24) == 0,
            $urandom_range(0, 9) < 7, 6'($urandom));
    end

    for (int k = 0; k < 10 && (exp_q.size() > 0 || m_valid); k++) begin
      cycle(0, 8'h00, 0, 0, 0, 1, 6'd0);
    end
    check("drain_empty", exp_q.size(), 0);
    check("drain_out_valid", out_valid, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/popcount_stream_acc.md
Name: popcount_stream_acc

Overview:
Parametrised sequential successor to the team's combinational ones-counter. It accepts a stream of WIDTH-bit words over a valid/ready handshake and, per word, emits the bit count (ones or zeros, selectable). It also emits a running per-frame total that saturates, plus a threshold flag. It sits between a bit-vector producer (e.g. an error-mask or occupancy-map source) and downstream statistics logic, and has one registered output stage with backpressure.

Parameters:
WIDTH, 8, input word width in bits (>=1)
ACC_W, 12, running-total width in bits (>= CNT_W)
CNT_W, $clog2(WIDTH+1), per-word count width (derived; not overridden)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  input word valid
in_ready  output  1  block can accept a word this cycle
in_data  input  WIDTH  word to count
in_last  input  1  word is last of its frame
count_zeros  input  1  0 = count ones, 1 = count zeros; sampled with each accepted word
clear  input  1  synchronous abort of the current frame total
thresh  input  ACC_W  threshold compared against the running total
out_valid  output  1  output stage holds a result
out_ready  input  1  downstream accepts the result
out_count  output  CNT_W  count for the word
out_total  output  ACC_W  saturating frame total, including this word
out_hit  output  1  out_total >= thresh, where thresh is sampled at accept
out_sat  output  1  frame total has saturated at some point in this frame (sticky within the frame)
out_last  output  1  copy of in_last for this word

Behaviour:
- Reset (async, rst=1): out_valid=0, out_count=0, out_total=0, out_hit=0, out_sat=0, out_last=0; internal frame accumulator=0; frame-start flag=1.
- in_ready = !out_valid || out_ready (combinational). Value is 1 out of reset.
- Accept occurs when in_valid && in_ready. Outputs are registered on the accept edge, so latency is 1 cycle. Full throughput is 1 word/cycle while out_ready=1.
- Output hold: while out_valid && !out_ready, all out_* values are held stable and no word is accepted.
- out_valid: set on accept; cleared when out_ready && !accept; stays 1 on a simultaneous pop and accept.
- Word count c:
  - count_zeros=0: number of 1 bits in in_data.
  - count_zeros=1: WIDTH minus the ones count.
  - Range is 0..WIDTH; never wraps.
- Frame accumulator (acc):
  - Base for the sum = 0 if the frame-start flag is set or clear=1; otherwise base = acc.
  - new = base + c, computed at ACC_W+1 bits.
  - If new > 2^ACC_W-1, then total = 2^ACC_W-1 and the sat event is set; otherwise total = new.
  - On accept: acc<=total; out_total<=total; out_count<=c; out_last<=in_last; out_hit<=(total>=thresh).
  - out_sat <= sat event OR (prior sticky sat AND base came from acc).
- Frame-start flag:
  - Set after accepting a word with in_last=1.
  - Set by clear when there is no accept that cycle.
  - Cleared on any other accept.
  - A clear without accept also zeroes acc and the sticky sat.
- clear in the same cycle as an accept: that word starts a fresh frame, so out_total = c. It does not alter the currently held output.
- clear while stalled: the held output is untouched. The next accepted word starts a new frame.
- An in_last word that saturates gives out_sat=1. The next word starts with out_sat=0.
- Reset mid-frame: all state returns to reset values. Any pending output is dropped.
- No X propagation: in_data and in_valid are only sampled when accepted.

Test Plan:
- WIDTH=8, out_ready=1. Send 0x00, 0x01, 0xFF, 0xA5 (last=1) -> next cycle each: out_count 0,1,8,4; out_total 0,1,9,13; out_last=1 on the 4th.
- Following 0x0F with count_zeros=1 -> out_count=4, out_total=4 (new frame); count_zeros=0 on 0xF0 -> out_count=4, out_total=8.
- ACC_W=4. Send 0xFF, 0xFF, 0x01 -> out_total 8, 15 (out_sat=1), 15 (out_sat=1). Then 0x03 with last=1, then 0x01 -> out_total=1, out_sat=0.
- thresh=10. Totals 8, 12 -> out_hit 0, 1. Change thresh to 20 while stalled -> held out_hit stays 1.
- out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0, outputs stable, no words lost. Then out_ready=1 with in_valid=1 -> back-to-back transfers, no bubble.
- Mid-frame clear with accept of 0x07 -> out_total=3. Assert rst for 1 cycle mid-frame -> out_valid=0, outputs zero, the next word's out_total equals its own count.
